// File: rtl/qlm_pkg.sv
`default_nettype none
// ==== qlm_pkg : mode encoding and leading-one detector for the multiplier (rev 1.0) ====
package qlm_pkg;

   localparam logic MODE_EXACT = 1'b0;
   localparam logic MODE_APX   = 1'b1;

   // The detector is written once at a fixed maximum width; callers cast the
   // index down to $clog2 of their own operand width.
   localparam int LOD_IN_W  = 64;
   localparam int LOD_OUT_W = 6;

   function automatic logic [LOD_OUT_W-1:0] lod(input logic [LOD_IN_W-1:0] v);
      logic [LOD_OUT_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < LOD_IN_W; i++)
         if (v[i]) idx = LOD_OUT_W'(i);
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/qlm_mitchell_core.sv
`default_nettype none
// ==== qlm_mitchell_core : combinational Mitchell log-domain product, truncated fraction (rev 1.0) ====
module qlm_mitchell_core #(
   parameter int WIDTH  = 16,
   parameter int FRAC_W = 4
) (
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic [2*WIDTH-1:0] p
);
   import qlm_pkg::*;

   localparam int KW = $clog2(WIDTH);
   localparam int PW = 2 * WIDTH;

   logic [KW-1:0]        ka, kb;
   logic [WIDTH-1:0]     xn, yn;
   logic [FRAC_W-1:0]    fa, fb;
   logic [FRAC_W:0]      s, mant;
   logic [KW:0]          sh;
   logic [PW+FRAC_W-1:0] wide;

   always_comb begin
      ka = KW'(lod(LOD_IN_W'(x)));
      kb = KW'(lod(LOD_IN_W'(y)));
      // Normalise so the leading one sits at the MSB; the fraction is then a fixed slice.
      xn = x << (KW'(WIDTH-1) - ka);
      yn = y << (KW'(WIDTH-1) - kb);
      fa = FRAC_W'(xn >> (WIDTH-1-FRAC_W));
      fb = FRAC_W'(yn >> (WIDTH-1-FRAC_W));
      s  = {1'b0, fa} + {1'b0, fb};
      // A fraction carry doubles the characteristic instead of adding the implicit one.
      mant = s[FRAC_W] ? s : {1'b1, s[FRAC_W-1:0]};
      sh   = {1'b0, ka} + {1'b0, kb} + {{KW{1'b0}}, s[FRAC_W]};
      wide = (PW+FRAC_W)'(mant) << sh;
      p    = (x == '0 || y == '0) ? '0 : PW'(wide >> FRAC_W);
   end

endmodule
`default_nettype wire

// File: rtl/qlm_mult_pipe.sv
`default_nettype none
// ==== qlm_mult_pipe : valid/ready pipelined multiplier, exact or Mitchell mode per beat (rev 1.0) ====
module qlm_mult_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 3,
   parameter int FRAC_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_x,
   input  logic [WIDTH-1:0]   in_y,
   input  logic               in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic               out_mode,
   output logic [CNT_W-1:0]   ops_done
);
   import qlm_pkg::*;

   localparam int PW = 2 * WIDTH;

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] adv;
   logic [WIDTH-1:0]  x_r, y_r;
   logic              mode_r;
   logic [PW-1:0]     p_r [STAGES-1];
   logic              m_r [STAGES-1];
   logic [PW-1:0]     apx_p, prod;

   qlm_mitchell_core #(.WIDTH(WIDTH), .FRAC_W(FRAC_W)) u_mitchell (
      .x (x_r),
      .y (y_r),
      .p (apx_p)
   );

   assign prod = (mode_r == MODE_APX) ? apx_p : PW'(x_r) * PW'(y_r);

   // A stage moves on if the sink takes the last beat or any later stage holds a bubble;
   // looking ahead directly keeps the ready chain free of combinational self-loops.
   for (genvar s = 0; s < STAGES; s++) begin : g_adv
      if (s == STAGES-1) begin : g_last
         assign adv[s] = vld[s] & out_ready;
      end else begin : g_mid
         assign adv[s] = vld[s] & (out_ready | ~(&vld[STAGES-1:s+1]));
      end
   end

   assign in_ready  = ~rst_n | ~vld[0] | adv[0];
   assign out_valid = vld[STAGES-1];
   assign out_p     = p_r[STAGES-2];
   assign out_mode  = m_r[STAGES-2];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld      <= '0;
         x_r      <= '0;
         y_r      <= '0;
         mode_r   <= 1'b0;
         ops_done <= '0;
         for (int s = 0; s < STAGES-1; s++) begin
            p_r[s] <= '0;
            m_r[s] <= 1'b0;
         end
      end else begin
         if (in_valid && in_ready) begin
            vld[0] <= 1'b1;
            x_r    <= in_x;
            y_r    <= in_y;
            mode_r <= in_mode;
         end else if (adv[0]) begin
            vld[0] <= 1'b0;
         end

         if (adv[0]) begin
            vld[1] <= 1'b1;
            p_r[0] <= prod;
            m_r[0] <= mode_r;
         end else if (adv[1]) begin
            vld[1] <= 1'b0;
         end

         for (int s = 2; s < STAGES; s++) begin
            if (adv[s-1]) begin
               vld[s]   <= 1'b1;
               p_r[s-1] <= p_r[s-2];
               m_r[s-1] <= m_r[s-2];
            end else if (adv[s]) begin
               vld[s] <= 1'b0;
            end
         end

         if (out_valid && out_ready)
            ops_done <= ops_done + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_qlm_mult_pipe.sv
`default_nettype none
// ==== tb_qlm_mult_pipe : directed vectors with hand-computed products for qlm_mult_pipe (rev 1.0) ====
module tb_qlm_mult_pipe;

   localparam int STAGES = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
   logic [15:0] in_x = '0, in_y = '0;
   wire         in_ready, out_valid, out_mode;
   wire  [31:0] out_p;
   wire  [15:0] ops_done;

   logic        in_valid2 = 1'b0, out_ready2 = 1'b1;
   wire         in_ready2, out_valid2, out_mode2;
   wire  [31:0] out_p2;
   wire  [3:0]  ops_done2;

   int          n_vec = 0, n_err = 0;
   logic [32:0] exp_beat = '0;
   logic [32:0] q[$], q2[$];
   logic [32:0] e, e2;

   always #5 clk = ~clk;

   qlm_mult_pipe #(.WIDTH(16), .STAGES(STAGES), .FRAC_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_p(out_p), .out_mode(out_mode), .ops_done(ops_done)
   );

   qlm_mult_pipe #(.WIDTH(16), .STAGES(2), .FRAC_W(4), .CNT_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .out_valid(out_valid2),
      .out_ready(out_ready2), .out_p(out_p2), .out_mode(out_mode2), .ops_done(ops_done2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: expected beats queued on input handshake, compared in order on output handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         q2.delete();
      end else begin
         if (in_valid && in_ready) q.push_back(exp_beat);
         if (out_valid && out_ready) begin
            if (q.size() == 0) check("stray_out", 64'(q.size()), 64'd1);
            else begin
               e = q.pop_front();
               check("prod", 64'(out_p), 64'(e[31:0]));
               check("mode", 64'(out_mode), 64'(e[32]));
            end
         end
         if (in_valid2 && in_ready2) q2.push_back(exp_beat);
         if (out_valid2 && out_ready2) begin
            if (q2.size() == 0) check("stray_out2", 64'(q2.size()), 64'd1);
            else begin
               e2 = q2.pop_front();
               check("prod2", 64'(out_p2), 64'(e2[31:0]));
               check("mode2", 64'(out_mode2), 64'(e2[32]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] x, input logic [15:0] y, input logic m,
                       input logic [31:0] p);
      int   guard;
      logic ok;
      guard    = 0;
      in_valid = 1'b1;
      in_x     = x;
      in_y     = y;
      in_mode  = m;
      exp_beat = {m, p};
      #1;
      do begin
         ok = in_ready;
         tick();
         guard++;
      end while (!ok && guard < 50);
      if (!ok) check("send_accept", 64'(ok), 64'd1);
   endtask

   task automatic drain();
      int g;
      g = 0;
      in_valid = 1'b0;
      while ((q.size() != 0 || q2.size() != 0) && g < 60) begin
         tick();
         g++;
      end
      check("drain_q", 64'(q.size() + q2.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int   i, n;
      logic acc;

      tick();
      tick();
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_p", 64'(out_p), 64'd0);
      check("rst_ops_done", 64'(ops_done), 64'd0);
      rst_n = 1'b1;

      // latency of a single exact beat
      in_valid = 1'b1; in_x = 16'd3; in_y = 16'd3; in_mode = 1'b0; exp_beat = {1'b0, 32'd9};
      tick();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check("latency", 64'(n), 64'(STAGES));
      check("lat_prod", 64'(out_p), 64'd9);
      tick();

      // approximate and exact corner vectors
      send(16'd3, 16'd3, 1'b1, 32'd8);
      send(16'd0, 16'd1234, 1'b1, 32'd0);
      send(16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
      send(16'd5, 16'd7, 1'b1, 32'd32);
      send(16'd2, 16'd3, 1'b1, 32'd6);
      send(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
      send(16'd1234, 16'd0, 1'b0, 32'd0);
      drain();

      // backpressure: 10 beats, sink stalled for the first 8 cycles
      do_reset();
      i = 0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         out_ready = (cyc >= 8);
         in_valid  = (i < 10);
         in_x      = 16'(i);
         in_y      = 16'(i + 1);
         in_mode   = 1'b0;
         exp_beat  = {1'b0, 32'(i * (i + 1))};
         #1;
         if (cyc == STAGES) check("bp_in_ready_full", 64'(in_ready), 64'd0);
         if (cyc == 7) check("bp_in_ready_held", 64'(in_ready), 64'd0);
         acc = in_valid && in_ready;
         tick();
         if (acc) i++;
         if (i == 10 && q.size() == 0 && cyc >= 8) break;
      end
      in_valid = 1'b0;
      check("bp_accepted", 64'(i), 64'd10);
      check("bp_ops_done", 64'(ops_done), 64'd10);

      // interleaved modes on 5*5
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++)
         send(16'd5, 16'd5, k[0], k[0] ? 32'd24 : 32'd25);
      drain();
      check("mix_ops_done", 64'(ops_done), 64'd18);

      // reset with the pipe full and the sink stalled
      out_ready = 1'b0;
      send(16'd7, 16'd7, 1'b0, 32'd49);
      send(16'd6, 16'd6, 1'b0, 32'd36);
      send(16'd4, 16'd4, 1'b0, 32'd16);
      in_valid = 1'b1; in_x = 16'd9; in_y = 16'd9; exp_beat = {1'b0, 32'd81};
      rst_n = 1'b0;
      #1;
      check("rst5_in_ready_during", 64'(in_ready), 64'd1);
      tick();
      rst_n = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rst5_out_valid", 64'(out_valid), 64'd0);
      check("rst5_ops_done", 64'(ops_done), 64'd0);
      check("rst5_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      repeat (10) tick();
      check("rst5_no_stale", 64'(ops_done), 64'd0);

      // counter wrap on the 4-bit, two-stage instance
      i = 0;
      for (int cyc = 0; cyc < 60 && i < 17; cyc++) begin
         in_valid2 = 1'b1;
         in_x      = 16'(i + 1);
         in_y      = 16'd3;
         in_mode   = 1'b0;
         exp_beat  = {1'b0, 32'(3 * (i + 1))};
         #1;
         acc = in_ready2;
         tick();
         if (acc) i++;
      end
      in_valid2 = 1'b0;
      drain();
      check("wrap_accepted", 64'(i), 64'd17);
      check("wrap_ops_done", 64'(ops_done2), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
